// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg
// Shared types and constants for the table-driven sequence counter controller.
//   state_t            controller FSM states
//   WIDTH_DEF          default count-code width
//   DEPTH_DEF          default table depth
//   DEFAULT_LAST_IDX   last index of the reset sequence
//   DEFAULT_CODES      the 11-code reset sequence, loaded into table[0..10]
//   default_code()     reset value for any table entry (00 beyond the sequence)
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WIDTH_DEF         = 8;
  localparam int DEPTH_DEF         = 16;
  localparam int DEFAULT_LAST_IDX  = 10;
  localparam int NUM_DEFAULT_CODES = 11;

  localparam logic [7:0] DEFAULT_CODES [NUM_DEFAULT_CODES] = '{
    8'h02, 8'h01, 8'h04, 8'h08, 8'h00, 8'h10,
    8'h11, 8'h20, 8'h40, 8'h41, 8'h80
  };

  // Constant-index scan keeps the lookup in range for any table depth.
  function automatic logic [7:0] default_code(input int i);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < NUM_DEFAULT_CODES; k++) begin
      if (k == i) c = DEFAULT_CODES[k];
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_table.sv
// seq_table
// DEPTH x WIDTH code table with reset-time defaults.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   we, waddr, wdata   single write port
//   raddr, rdata       single combinational read port
module seq_table
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDXW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDXW-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(default_code(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_counter_ctrl.sv
// seq_counter_ctrl
// Run/stop/step sequencer over a programmable table of count codes.
// Optional build macro: SEQ_CTRL_DIR_EN adds the 'dir' input (1 = step backwards).
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   tick                          advance strobe while running
//   cmd_start, cmd_stop, cmd_step run / pause / single-step commands
//   mode_loop                     1 = wrap at end, 0 = one-shot (latched on start)
//   cfg_we, cfg_addr, cfg_data    table write port (IDLE/DONE only)
//   len_we, len_data              last-index write (IDLE/DONE only)
//   dir                           direction, only with SEQ_CTRL_DIR_EN
//   count, idx                    current code and its table index
//   busy                          running or paused
//   done, wrap, cfg_err           one-cycle event pulses
//
// state | meaning
// IDLE  | out of reset, count follows table[idx]
// RUN   | advancing on tick
// PAUSE | halted, cmd_step advances one entry
// DONE  | one-shot finished, count follows table[idx]
module seq_counter_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
`ifdef SEQ_CTRL_DIR_EN
  input  logic             dir,
`endif
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_step,
  input  logic             mode_loop,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             len_we,
  input  logic [IDXW-1:0]  len_data,
  output logic [WIDTH-1:0] count,
  output logic [IDXW-1:0]  idx,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cfg_err
);

  state_t           state, state_next;
  logic [IDXW-1:0]  idx_next;
  logic [IDXW-1:0]  last_idx;
  logic             loop_flag, loop_next;
  logic             advance;
  logic             at_end;
  logic             wrap_ev, done_ev;
  logic             cfg_ok, tab_we, len_ok, cfg_rej;
  logic [WIDTH-1:0] rd_data;

  // count is always reloaded from the entry idx will hold after this edge,
  // so the single read port serves refresh, start and advance alike.
  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tab_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_next),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // An index past last_idx (after shortening the sequence) counts as the end.
  assign at_end = (idx >= last_idx);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    loop_next  = loop_flag;
    advance    = 1'b0;
    wrap_ev    = 1'b0;
    done_ev    = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (cmd_start) begin
          state_next = ST_RUN;
          idx_next   = '0;
          loop_next  = mode_loop;
        end
      end
      ST_RUN: begin
        if (cmd_stop)  state_next = ST_PAUSE;
        else if (tick) advance    = 1'b1;
      end
      ST_PAUSE: begin
        // A stop held here still outranks start: we stay paused.
        if (cmd_stop)       state_next = ST_PAUSE;
        else if (cmd_start) state_next = ST_RUN;
        else if (cmd_step)  advance    = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    if (advance) begin
`ifdef SEQ_CTRL_DIR_EN
      if (dir) begin
        if (idx != '0) begin
          idx_next = idx - IDXW'(1);
        end else if (loop_flag) begin
          idx_next = last_idx;
          wrap_ev  = 1'b1;
        end else begin
          state_next = ST_DONE;
          done_ev    = 1'b1;
        end
      end else
`endif
      begin
        if (!at_end) begin
          idx_next = idx + IDXW'(1);
        end else if (loop_flag) begin
          idx_next = '0;
          wrap_ev  = 1'b1;
        end else begin
          state_next = ST_DONE;
          done_ev    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy    = (state == ST_RUN) || (state == ST_PAUSE);
    cfg_ok  = (state == ST_IDLE) || (state == ST_DONE);
    tab_we  = cfg_we && cfg_ok;
    len_ok  = len_we && cfg_ok;
    cfg_rej = (cfg_we || len_we) && !cfg_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      count     <= WIDTH'(default_code(0));
      last_idx  <= IDXW'(DEFAULT_LAST_IDX);
      loop_flag <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      idx       <= idx_next;
      count     <= rd_data;
      loop_flag <= loop_next;
      done      <= done_ev;
      wrap      <= wrap_ev;
      cfg_err   <= cfg_rej;
      if (len_ok) last_idx <= len_data;
    end
  end

endmodule
